// File: rtl/exec_writeback.sv
// Execute/writeback stage: single-cycle ALU plus shift-add multiply, writing a
// 16 x 32-bit register bank that is exported to decode.
module exec_writeback #(
  parameter int unsigned NREGS      = 16,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        activateExec,
  input  logic [2:0]  opcode,
  input  logic [31:0] dataOpa,
  input  logic [31:0] dataOpb,
  input  logic [3:0]  addrMor,
  output logic [31:0] regbank [0:NREGS-1],
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = $clog2(MUL_CYCLES);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WB} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [DW-1:0]   a_q, a_d;      // operand A, doubles as shifting multiplicand
  logic [DW-1:0]   b_q, b_d;      // operand B, doubles as shifting multiplier
  logic [3:0]      addr_q, addr_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   result_q, result_d;
  logic            done_q, done_d;
  logic [DW-1:0]   regs_q [0:NREGS-1];

  logic            accept_c;
  logic            wr_en_c;
  logic [DW-1:0]   alu_c;
  logic [DW-1:0]   wr_data_c;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (activateExec) state_d = (opcode == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC: state_d = S_IDLE;
      S_MUL:  if (cnt_q == CW'(MUL_CYCLES - 1)) state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs and write-data selection
  always_comb begin
    busy      = (state_q != S_IDLE);
    accept_c  = (state_q == S_IDLE) && activateExec;
    wr_en_c   = (state_q == S_EXEC) || (state_q == S_WB);
    alu_c     = '0;
    case (op_q)
      OP_ADD: alu_c = a_q + b_q;
      OP_SUB: alu_c = a_q - b_q;
      OP_AND: alu_c = a_q & b_q;
      OP_OR:  alu_c = a_q | b_q;
      OP_XOR: alu_c = a_q ^ b_q;
      OP_SHL: alu_c = a_q << b_q[4:0];
      OP_MUL: alu_c = acc_q;
      OP_MOV: alu_c = b_q;
      default: alu_c = '0;
    endcase
    wr_data_c = (state_q == S_WB) ? acc_q : alu_c;
  end

  // Datapath next-state
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    addr_d   = addr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = wr_en_c;
    if (accept_c) begin
      op_d   = opcode;
      a_d    = dataOpa;
      b_d    = dataOpb;
      addr_d = addrMor;
      acc_d  = '0;
      cnt_d  = '0;
    end else if (state_q == S_MUL) begin
      if (b_q[0]) acc_d = acc_q + a_q;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + CW'(1);
    end
    if (wr_en_c) result_d = wr_data_c;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      addr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      addr_q   <= addr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Register bank
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (wr_en_c) begin
      regs_q[addr_q] <= wr_data_c;
    end
  end

  assign regbank = regs_q;
  assign result  = result_q;
  assign done    = done_q;

endmodule

// File: doc/exec_writeback.md
# exec_writeback

Execute and writeback stage of the 16-bit-instruction processor. It accepts the operation and operand values latched by the decode stage, computes the result, and writes it into the 16 x 32-bit register bank. The block owns that register bank and drives it back to decode as the `regbank` array. Single-cycle ALU operations sit alongside a multi-cycle shift-add multiply, coordinated by a small FSM with a busy/done handshake.

## Interface
- `NREGS`, 16: number of 32-bit registers; fixed to match the 4-bit register address.
- `MUL_CYCLES`, 32: number of multiply iterations, one per multiplier bit.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `activateExec` in 1: operands valid; sampled only while idle.
- `opcode` in 3: operation select from decode.
- `dataOpa` in 32: operand A.
- `dataOpb` in 32: operand B (register value or sign-extended immediate).
- `addrMor` in 4: destination register index.
- `regbank` out 32 x [0:15]: register bank contents, read by decode.
- `result` out 32: last value written.
- `busy` out 1: high while the FSM is not IDLE.
- `done` out 1: one-cycle pulse after each register write.

## Operation
- Opcodes:
  - 000 ADD: a+b.
  - 001 SUB: a-b.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: a << b[4:0], zero fill.
  - 110 MUL: low 32 bits of a*b.
  - 111 MOV: result = b.
- All arithmetic is modulo 2^32; no flags, no overflow detection. `dataOpb` is used exactly as received; no extra sign handling.
- All 16 registers are writable, including register 0.
- FSM states: IDLE, EXEC, MUL, WB.
  - IDLE: on `activateExec`=1, latch opcode, A, B and addrMor. Go to MUL if opcode=110, else EXEC.
  - EXEC: compute from the latched operands, write `regbank[addr]` and `result`, set `done`, go to IDLE.
  - MUL: each edge, if the low bit of the multiplier is set, acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, cnt++. When cnt == MUL_CYCLES-1 (last iteration), go to WB.
  - WB: write acc into `regbank[addr]` and `result`, set `done`, go to IDLE.
- `activateExec` while busy: ignored, not queued. The upstream stage must wait for `busy`=0.
- Operands are latched at accept, so changes on the inputs afterward have no effect.

## Timing
- Reset values: all `regbank` entries 0, `result`=0, `busy`=0, `done`=0, state IDLE, cnt=0, acc=0.
- ALU ops (all except MUL):
  - accept at edge E0;
  - write at E1, so `regbank`, `result` and `done`=1 are visible after E1;
  - `done` cleared at E2;
  - `busy` is high for exactly one cycle (E0 to E1).
- MUL:
  - accept at E0;
  - iterations at E1..E32;
  - write at E33;
  - `busy` is high for 33 cycles.
- `done` is high during the first IDLE cycle after a write. A new `activateExec` in that cycle is accepted, giving back-to-back throughput of one op per 2 cycles.
- Decode sees the written value from the cycle after the write edge; there is no bypass path.
- `busy` is combinational from state (state != IDLE). `done` is registered.
- Reset asserted mid-operation: abort immediately with no register write, and all outputs return to reset values.

## Test plan
- Reset, then ADD with a=5, b=7, addr=3 -> R3=12, `result`=12, `done` high for one cycle after E1, `busy` high for 1 cycle.
- SUB with a=0, b=1, addr=15 -> R15=0xFFFFFFFF. SHL with a=1, b=31 -> 0x80000000. SHL with b=0x25 (b[4:0]=5) -> 1<<5=0x20.
- MUL with a=0x10000, b=0x10001, addr=4 -> R4=0x00010000 (truncated), `busy` high for 33 cycles, `done` one cycle after E33. MUL with a=0xFFFFFFFF, b=0xFFFFFFFF -> 1.
- `activateExec` held high with changing inputs during a MUL -> only the first op is executed; a new op is accepted in the `done` cycle and completes 2 edges later.
- Assert `reset` at iteration 16 of a MUL targeting R2 holding 0x1234 -> R2=0 (reset clears the bank), `busy`=0 and `done`=0 immediately, with no spurious write after release.
- MOV 0xFFFFFF80 (sign-extended immediate) into each of R0..R15, then AND/OR/XOR against known values -> all registers writable, correct bitwise results, unaddressed registers unchanged.
